spram_pm: RTL and testbench
===========================

Name: spram_pm

Overview:
- Parametrised, power-managed single-port RAM model. Generalises the fixed 16x16K nibble-masked SPRAM model in four ways: configurable data width, depth and mask granularity; selectable read latency; an explicit power-state FSM with wake-up delay counters; and READY/VALID/ERR status.
- Used in simulation and for behavioural replacement of on-chip scratchpad RAM in the accelerator memory subsystem.

Parameters:
- DATA_W, 16, data word width; must be a multiple of MASK_GRAN.
- ADDR_W, 14, address width; depth = 2**ADDR_W words.
- MASK_GRAN, 4, bits per write-mask lane; lanes = DATA_W/MASK_GRAN.
- READ_LAT, 1, read latency in clock edges; legal values 1 or 2.
- WAKE_SLEEP_CYC, 16, cycles from SLEEP release to READY.
- WAKE_STBY_CYC, 2, cycles from STANDBY release to READY.
- INIT_FILE, "", hex image for $readmemh; empty means zero-fill.

Ports:
- CLOCK  in  1  clock; all state changes on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- ADDRESS  in  ADDR_W  word address.
- DATAIN  in  DATA_W  write data.
- MASKWREN  in  DATA_W/MASK_GRAN  per-lane write enable.
- WREN  in  1  1 = write, 0 = read.
- CHIPSELECT  in  1  access request.
- STANDBY  in  1  request low-leakage standby; contents retained.
- SLEEP  in  1  request sleep; contents retained, DATAOUT forced to 0.
- POWEROFF  in  1  active-low power gate; 0 = off, contents lost.
- DATAOUT  out  DATA_W  read data.
- DATAOUT_VALID  out  1  one-cycle pulse when DATAOUT carries new read data.
- READY  out  1  1 only in ACTIVE; accesses are accepted only while READY = 1.
- PSTATE  out  3  encoded FSM state.
- ERR  out  1  one-cycle pulse when an access is dropped.
- LOST  out  1  sticky; contents were destroyed by a power-off.

Behaviour:
- Reset (RESET_N low):
  - State = OFF; DATAOUT = 0; DATAOUT_VALID = 0; ERR = 0; READY = 0; wake counter = 0.
  - LOST is unchanged. Memory array is not touched by reset.
- FSM states: OFF = 0, SLEEP = 1, STBY = 2, WAKE = 3, ACTIVE = 4.
  - Request priority: POWEROFF low > SLEEP > STANDBY.
  - Any state, POWEROFF = 0 -> OFF. Entering OFF from a non-OFF state sets LOST and fills the array with X (simulation only).
  - OFF, POWEROFF = 1, SLEEP = 1 -> SLEEP.
  - OFF, POWEROFF = 1, SLEEP = 0 -> WAKE; counter loads WAKE_SLEEP_CYC.
  - ACTIVE or WAKE, SLEEP = 1 -> SLEEP. ACTIVE or WAKE, STANDBY = 1 -> STBY.
  - SLEEP, SLEEP = 0 -> WAKE; counter loads WAKE_SLEEP_CYC.
  - STBY, STANDBY = 0 -> WAKE; counter loads WAKE_STBY_CYC. STBY, SLEEP = 1 -> SLEEP.
  - WAKE: counter decrements each edge. When counter == 1 and no request is pending, next state is ACTIVE. A load value of 0 goes directly to ACTIVE.
- Output behaviour per state:
  - OFF and SLEEP: DATAOUT = 0.
  - STBY and WAKE: DATAOUT holds its value.
  - Entering SLEEP, STBY or OFF flushes the in-flight read pipeline stage: no VALID is issued.
- Access rules:
  - An access is accepted only when CHIPSELECT = 1 and state == ACTIVE at the edge.
  - CHIPSELECT = 1 in any other state: access is dropped and ERR pulses for 1 cycle.
- Write:
  - Lane i of mem[ADDRESS] is updated iff MASKWREN[i] = 1.
  - DATAOUT holds its previous value and VALID stays 0. This deliberately differs from the older model, which drove X.
- Read latency:
  - READ_LAT = 1: DATAOUT = mem[ADDRESS] and VALID = 1 after the accepting edge.
  - READ_LAT = 2: a registered stage is added, so data and VALID appear one edge later. Back-to-back reads are fully pipelined at 1 per cycle.
- Write then read of the same address on consecutive cycles: the read returns the written data.
- LOST clears on the first accepted write after power-on. It is a status flag only.
- Out-of-range addresses cannot occur, since depth = 2**ADDR_W.
- Width rules:
  - Wake counter width = $clog2(max(WAKE_SLEEP_CYC, WAKE_STBY_CYC) + 1).
  - Elaboration error if DATA_W % MASK_GRAN != 0 or READ_LAT is not in {1, 2}.

Decomposition:
- Package spram_pm_pkg holds:
  - pstate_e enum: OFF, SLEEP, STBY, WAKE, ACTIVE, with the encodings above.
  - Function lanes(DATA_W, MASK_GRAN).
  - Function cnt_w(a, b).
- Sub-module spram_pm_ctrl holds the power FSM, wake counter, READY, ERR and LOST.
- The top level keeps the array, mask-write logic and read pipeline.

Test Plan:
- Defaults, reset release with POWEROFF = 1, SLEEP = 0 -> PSTATE = WAKE for 16 cycles, then ACTIVE and READY = 1. Write 0xBEEF to 0x0100 with mask 4'hF, then read -> DATAOUT = 0xBEEF with a VALID pulse 1 edge after the read.
- Masked write of 0x1234 with MASKWREN = 4'b0101 over 0xBEEF -> read returns 0xB2E4.
- READ_LAT = 2, reads of 0x0000..0x0003 on back-to-back cycles -> 4 consecutive VALID pulses, first 2 edges after the first read, data in address order.
- Assert STANDBY for 5 cycles -> DATAOUT holds 0xB2E4 and a read during STBY pulses ERR. After release, READY returns after exactly 2 cycles.
- SLEEP asserted during an in-flight READ_LAT = 2 read -> no VALID, DATAOUT = 0 on the next edge. Re-read after wake returns preserved data.
- POWEROFF pulsed low for 1 cycle -> LOST = 1, READY = 0, wake of 16 cycles. A write to 0x0100 clears LOST. RESET_N asserted mid-wake -> OFF immediately.

Source files
------------

// File: rtl/spram_pm_pkg.sv
// spram_pm_pkg: shared power-state encoding and sizing helpers for spram_pm
package spram_pm_pkg;

  typedef enum logic [2:0] {
    OFF    = 3'd0,
    SLEEP  = 3'd1,
    STBY   = 3'd2,
    WAKE   = 3'd3,
    ACTIVE = 3'd4
  } pstate_e;

  function automatic int lanes(input int data_w, input int mask_gran);
    return data_w / mask_gran;
  endfunction

  function automatic int cnt_w(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction

endpackage

// File: rtl/spram_pm_ctrl.sv
// spram_pm_ctrl: power-state FSM, wake counter and READY/ERR/LOST status
module spram_pm_ctrl import spram_pm_pkg::*; #(
  parameter int WAKE_SLEEP_CYC = 16,
  parameter int WAKE_STBY_CYC  = 2,
  parameter int CW             = cnt_w(WAKE_SLEEP_CYC, WAKE_STBY_CYC)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs,
  input  logic       wren,
  input  logic       standby,
  input  logic       sleep,
  input  logic       poweroff,
  output logic [2:0] pstate,
  output logic       ready,
  output logic       accept,
  output logic       flush,
  output logic       zero,
  output logic       wipe,
  output logic       err,
  output logic       lost
);

  localparam logic [CW-1:0] LS = CW'(WAKE_SLEEP_CYC);
  localparam logic [CW-1:0] LB = CW'(WAKE_STBY_CYC);

  pstate_e state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  // a zero wake load skips WAKE entirely
  always_comb begin
    nxt = state;
    cnt_nxt = cnt;
    if (!poweroff) nxt = OFF;
    else case (state)
      OFF, SLEEP:
        if (sleep) nxt = SLEEP;
        else begin
          nxt = LS == '0 ? ACTIVE : WAKE;
          cnt_nxt = LS;
        end
      STBY:
        if (sleep) nxt = SLEEP;
        else if (!standby) begin
          nxt = LB == '0 ? ACTIVE : WAKE;
          cnt_nxt = LB;
        end
      WAKE, ACTIVE:
        if (sleep) nxt = SLEEP;
        else if (standby) nxt = STBY;
        else if (state == WAKE) begin
          nxt = cnt > CW'(1) ? WAKE : ACTIVE;
          cnt_nxt = cnt > CW'(1) ? cnt - 1'b1 : '0;
        end
      default: nxt = OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= OFF;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      err <= cs && state != ACTIVE;
    end

  // survives reset: only a real power-off or a fresh write changes it
  always_ff @(posedge clk)
    if (wipe) lost <= 1'b1;
    else if (accept && wren) lost <= 1'b0;

  assign pstate = state;
  assign ready  = state == ACTIVE;
  assign accept = cs && ready;
  assign wipe   = nxt == OFF && state != OFF;
  assign flush  = nxt inside {OFF, SLEEP, STBY};
  assign zero   = nxt inside {OFF, SLEEP};

endmodule

// File: rtl/spram_pm.sv
// spram_pm: parametrised power-managed single-port RAM with lane-masked writes
module spram_pm #(
  parameter int    DATA_W         = 16,
  parameter int    ADDR_W         = 14,
  parameter int    MASK_GRAN      = 4,
  parameter int    READ_LAT       = 1,
  parameter int    WAKE_SLEEP_CYC = 16,
  parameter int    WAKE_STBY_CYC  = 2,
  parameter string INIT_FILE      = ""
) (
  input  logic                        CLOCK,
  input  logic                        RESET_N,
  input  logic [ADDR_W-1:0]           ADDRESS,
  input  logic [DATA_W-1:0]           DATAIN,
  input  logic [DATA_W/MASK_GRAN-1:0] MASKWREN,
  input  logic                        WREN,
  input  logic                        CHIPSELECT,
  input  logic                        STANDBY,
  input  logic                        SLEEP,
  input  logic                        POWEROFF,
  output logic [DATA_W-1:0]           DATAOUT,
  output logic                        DATAOUT_VALID,
  output logic                        READY,
  output logic [2:0]                  PSTATE,
  output logic                        ERR,
  output logic                        LOST
);

  localparam int LANES = spram_pm_pkg::lanes(DATA_W, MASK_GRAN);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] bm, out_d;
  logic accept, flush, zero, wipe, rd, out_v;

  if (DATA_W % MASK_GRAN != 0 || (READ_LAT != 1 && READ_LAT != 2)) begin : g_bad
    $error("spram_pm: illegal DATA_W/MASK_GRAN/READ_LAT (INIT_FILE %s)", INIT_FILE);
  end

  spram_pm_ctrl #(
    .WAKE_SLEEP_CYC(WAKE_SLEEP_CYC),
    .WAKE_STBY_CYC (WAKE_STBY_CYC)
  ) u_ctrl (
    .clk     (CLOCK),
    .rst_n   (RESET_N),
    .cs      (CHIPSELECT),
    .wren    (WREN),
    .standby (STANDBY),
    .sleep   (SLEEP),
    .poweroff(POWEROFF),
    .pstate  (PSTATE),
    .ready   (READY),
    .accept  (accept),
    .flush   (flush),
    .zero    (zero),
    .wipe    (wipe),
    .err     (ERR),
    .lost    (LOST)
  );

  for (genvar i = 0; i < LANES; i++) begin : g_bm
    assign bm[i*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{MASKWREN[i]}};
  end

  always_ff @(posedge CLOCK)
    if (wipe) mem <= '{default: 'x};
    else if (accept && WREN) mem[ADDRESS] <= (mem[ADDRESS] & ~bm) | (DATAIN & bm);

  assign rd = accept && !WREN && !flush;

  if (READ_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] s1_data;
    logic s1_v;
    always_ff @(posedge CLOCK or negedge RESET_N)
      if (!RESET_N) begin
        s1_v <= 1'b0;
        s1_data <= '0;
      end else begin
        s1_v <= rd;
        if (rd) s1_data <= mem[ADDRESS];
      end
    assign out_v = s1_v && !flush;
    assign out_d = s1_data;
  end else begin : g_lat1
    assign out_v = rd;
    assign out_d = mem[ADDRESS];
  end

  always_ff @(posedge CLOCK or negedge RESET_N)
    if (!RESET_N) begin
      DATAOUT <= '0;
      DATAOUT_VALID <= 1'b0;
    end else begin
      DATAOUT_VALID <= out_v;
      DATAOUT <= zero ? '0 : out_v ? out_d : DATAOUT;
    end

endmodule

// File: tb/tb_spram_pm.sv
// tb_spram_pm: directed, table and random checks of spram_pm at read latency 1 and 2
module tb_spram_pm;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [13:0] addr = '0;
  logic [15:0] din = '0;
  logic [3:0] mask = '0;
  logic wren = 1'b0, cs = 1'b0, standby = 1'b0, sleep = 1'b0, poweroff = 1'b1;
  logic [15:0] d1, d2;
  logic v1, v2, r1, r2, e1, e2, l1, l2;
  logic [2:0] p1, p2;
  int checks = 0, errors = 0, n;

  typedef struct {
    logic [13:0] a;
    logic [15:0] d1;
    logic [3:0]  m;
    logic [15:0] d2;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl [4];

  logic [15:0] ref_mem [16];
  logic [15:0] exp1 = '0, exp2 = '0, pend = '0;
  logic pend_v = 1'b0;

  always #5 clk = ~clk;

  spram_pm #(.READ_LAT(1)) u1 (
    .CLOCK(clk), .RESET_N(rst_n), .ADDRESS(addr), .DATAIN(din), .MASKWREN(mask),
    .WREN(wren), .CHIPSELECT(cs), .STANDBY(standby), .SLEEP(sleep), .POWEROFF(poweroff),
    .DATAOUT(d1), .DATAOUT_VALID(v1), .READY(r1), .PSTATE(p1), .ERR(e1), .LOST(l1)
  );

  spram_pm #(.READ_LAT(2)) u2 (
    .CLOCK(clk), .RESET_N(rst_n), .ADDRESS(addr), .DATAIN(din), .MASKWREN(mask),
    .WREN(wren), .CHIPSELECT(cs), .STANDBY(standby), .SLEEP(sleep), .POWEROFF(poweroff),
    .DATAOUT(d2), .DATAOUT_VALID(v2), .READY(r2), .PSTATE(p2), .ERR(e2), .LOST(l2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic c, input logic w, input logic [13:0] a,
                       input logic [15:0] d, input logic [3:0] m);
    cs = c;
    wren = w;
    addr = a;
    din = d;
    mask = m;
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [3:0] m);
    merge = old;
    for (int l = 0; l < 4; l++)
      if (m[l]) merge[l*4 +: 4] = d[l*4 +: 4];
  endfunction

  // one ACTIVE-state cycle against the reference model
  task automatic cyc(input logic c, input logic w, input logic [13:0] a,
                     input logic [15:0] d, input logic [3:0] m);
    logic rd, ev2;
    logic [15:0] cur;
    rd = c && !w;
    cur = ref_mem[a[3:0]];
    drive(c, w, a, d, m);
    ev2 = pend_v;
    if (pend_v) exp2 = pend;
    pend_v = rd;
    pend = cur;
    if (rd) exp1 = cur;
    if (c && w) ref_mem[a[3:0]] = merge(cur, d, m);
    step();
    chk("rnd_d1", d1, exp1);
    chk("rnd_v1", v1, rd);
    chk("rnd_d2", d2, exp2);
    chk("rnd_v2", v2, ev2);
    chk("rnd_err", e1, 0);
    chk("rnd_ready", r1, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{14'h0000, 16'hAAAA, 4'b0011, 16'h5555, 16'hAA55};
    tbl[1] = '{14'h0001, 16'h1234, 4'b1000, 16'hF000, 16'hF234};
    tbl[2] = '{14'h0002, 16'hFFFF, 4'b0000, 16'h0000, 16'hFFFF};
    tbl[3] = '{14'h0003, 16'h0F0F, 4'b1111, 16'hC3A5, 16'hC3A5};

    step();
    step();
    chk("rst_pstate", p1, 0);
    chk("rst_pstate2", p2, 0);
    chk("rst_ready", r1, 0);
    chk("rst_dout", d1, 0);
    chk("rst_valid", v1, 0);
    chk("rst_err", e1, 0);
    rst_n = 1'b1;
    step();
    n = 0;
    while (p1 == 3'd3 && n < 40) begin
      n++;
      step();
    end
    chk("wake_len", n, 16);
    chk("active", p1, 4);
    chk("ready", r1, 1);

    drive(1, 1, 14'h0100, 16'hBEEF, 4'hF);
    step();
    chk("wr_no_valid", v1, 0);
    drive(1, 0, 14'h0100, 16'h0, 4'h0);
    step();
    chk("rd1_data", d1, 16'hBEEF);
    chk("rd1_valid", v1, 1);
    chk("rd2_early", v2, 0);
    chk("lost_after_wr", l1, 0);
    drive(0, 0, 14'h0, 16'h0, 4'h0);
    step();
    chk("rd2_data", d2, 16'hBEEF);
    chk("rd2_valid", v2, 1);
    chk("rd1_pulse", v1, 0);

    drive(1, 1, 14'h0100, 16'h1234, 4'b0101);
    step();
    drive(1, 0, 14'h0100, 16'h0, 4'h0);
    step();
    chk("mask_d1", d1, 16'hB2E4);
    drive(0, 0, 14'h0, 16'h0, 4'h0);
    step();
    chk("mask_d2", d2, 16'hB2E4);

    for (int i = 0; i < 4; i++) begin
      drive(1, 1, tbl[i].a, tbl[i].d1, 4'hF);
      step();
      drive(1, 1, tbl[i].a, tbl[i].d2, tbl[i].m);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(1, 0, tbl[i].a, 16'h0, 4'h0);
      else drive(0, 0, 14'h0, 16'h0, 4'h0);
      step();
      if (i < 4) begin
        chk("tbl_d1", d1, tbl[i].exp);
        chk("tbl_v1", v1, 1);
      end
      if (i == 0) chk("tbl_v2_first", v2, 0);
      else begin
        chk("tbl_d2", d2, tbl[i-1].exp);
        chk("tbl_v2", v2, 1);
      end
    end
    step();
    chk("tbl_v2_end", v2, 0);

    drive(1, 0, 14'h0100, 16'h0, 4'h0);
    step();
    drive(0, 0, 14'h0, 16'h0, 4'h0);
    step();
    standby = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) drive(1, 0, 14'h0100, 16'h0, 4'h0);
      else drive(0, 0, 14'h0, 16'h0, 4'h0);
      step();
      chk("stby_state", p1, 2);
      chk("stby_hold1", d1, 16'hB2E4);
      chk("stby_hold2", d2, 16'hB2E4);
      chk("stby_err", e1, i == 2);
      chk("stby_valid", v1, 0);
    end
    drive(0, 0, 14'h0, 16'h0, 4'h0);
    standby = 1'b0;
    step();
    chk("stby_wake", p1, 3);
    n = 0;
    while (!r1 && n < 10) begin
      step();
      n++;
    end
    chk("stby_wake_len", n, 2);

    drive(1, 0, 14'h0100, 16'h0, 4'h0);
    step();
    chk("pre_sleep_v1", v1, 1);
    drive(0, 0, 14'h0, 16'h0, 4'h0);
    sleep = 1'b1;
    step();
    chk("sleep_state", p1, 1);
    chk("sleep_flush_v2", v2, 0);
    chk("sleep_dout2", d2, 0);
    chk("sleep_dout1", d1, 0);
    step();
    step();
    sleep = 1'b0;
    step();
    n = 0;
    while (!r1 && n < 40) begin
      step();
      n++;
    end
    chk("sleep_wake_len", n, 16);
    drive(1, 0, 14'h0100, 16'h0, 4'h0);
    step();
    chk("sleep_keep1", d1, 16'hB2E4);
    drive(0, 0, 14'h0, 16'h0, 4'h0);
    step();
    chk("sleep_keep2", d2, 16'hB2E4);
    chk("sleep_keep2_v", v2, 1);

    poweroff = 1'b0;
    step();
    chk("off_state", p1, 0);
    chk("off_lost", l1, 1);
    chk("off_ready", r1, 0);
    poweroff = 1'b1;
    step();
    chk("off_wake", p1, 3);
    n = 0;
    while (!r1 && n < 40) begin
      step();
      n++;
    end
    chk("off_wake_len", n, 16);
    drive(1, 1, 14'h0100, 16'h5A5A, 4'hF);
    step();
    chk("lost_clear", l1, 0);
    drive(1, 0, 14'h0100, 16'h0, 4'h0);
    step();
    chk("off_rewrite", d1, 16'h5A5A);
    drive(0, 0, 14'h0, 16'h0, 4'h0);
    step();

    poweroff = 1'b0;
    step();
    poweroff = 1'b1;
    step();
    step();
    step();
    chk("midwake", p1, 3);
    rst_n = 1'b0;
    #1;
    chk("rst_async", p1, 0);
    chk("rst_async_ready", r1, 0);
    chk("rst_lost_kept", l1, 1);
    step();
    rst_n = 1'b1;
    step();
    n = 0;
    while (!r1 && n < 40) begin
      step();
      n++;
    end
    chk("rst_wake_len", n, 16);

    exp1 = '0;
    exp2 = '0;
    pend_v = 1'b0;
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 14'(i), 16'($urandom), 4'hF);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, 1'($urandom), 14'($urandom_range(0, 15)),
          16'($urandom), 4'($urandom));
    cyc(1'b0, 1'b0, 14'h0, 16'h0, 4'h0);
    cyc(1'b0, 1'b0, 14'h0, 16'h0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
